// File: rtl/axi_pkg.sv
// axi_pkg: AXI burst/response encodings and the write-target FSM state enum
package axi_pkg;
  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_e;
  typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11} resp_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_e;
endpackage

// File: rtl/byte_enable_ram.sv
// byte_enable_ram: one byte-enabled write port, one registered read port (read-old-data)
module byte_enable_ram #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic [DATA_WIDTH/8-1:0]    wstrb_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (we_i && wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_write_target.sv
// axi_write_target: single-outstanding AXI4 INCR write slave backed by a byte-enabled RAM
module axi_write_target
  import axi_pkg::*;
#(
  parameter int ID_WIDTH = 24,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH = 1024
) (
  input  logic                      data_aclk,
  input  logic                      data_areset,
  input  logic [ID_WIDTH-1:0]       data_awid,
  input  logic [ADDR_WIDTH-1:0]     data_awaddr,
  input  logic [7:0]                data_awlen,
  input  logic [2:0]                data_awsize,
  input  logic [1:0]                data_awburst,
  input  logic                      data_awvalid,
  output logic                      data_awready,
  input  logic [DATA_WIDTH-1:0]     data_wdata,
  input  logic [DATA_WIDTH/8-1:0]   data_wstrb,
  input  logic                      data_wlast,
  input  logic                      data_wvalid,
  output logic                      data_wready,
  output logic [ID_WIDTH-1:0]       data_bid,
  output logic [1:0]                data_bresp,
  output logic                      data_bvalid,
  input  logic                      data_bready,
  input  logic [$clog2(DEPTH)-1:0]  debug_raddr,
  output logic [DATA_WIDTH-1:0]     debug_rdata
);
  localparam int OFF = $clog2(DATA_WIDTH/8);
  localparam int IW = $clog2(DEPTH);
  state_e state_q, state_d;
  resp_e resp_q, resp_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic store_q, store_d, we, last, decerr, slverr, unused;
  assign unused = ^data_awaddr[OFF-1:0];
  assign decerr = |data_awaddr[ADDR_WIDTH-1:OFF+IW];
  assign slverr = data_awburst != BURST_INCR || data_awsize != 3'(OFF);
  assign last = cnt_q == len_q;
  always_comb begin
    state_d = state_q;
    resp_d = resp_q;
    id_d = id_q;
    len_d = len_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    store_d = store_q;
    we = 1'b0;
    case (state_q)
      ST_IDLE: if (data_awvalid) begin
        state_d = ST_DATA;
        id_d = data_awid;
        len_d = data_awlen;
        cnt_d = '0;
        idx_d = data_awaddr[OFF +: IW];
        resp_d = decerr ? RESP_DECERR : slverr ? RESP_SLVERR : RESP_OKAY;
        store_d = !decerr && !slverr;
      end
      ST_DATA: if (data_wvalid) begin
        we = store_q;
        idx_d = idx_q + 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (data_wlast != last && resp_q == RESP_OKAY) resp_d = RESP_SLVERR;
        if (last) state_d = ST_RESP;
      end
      ST_RESP: if (data_bready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge data_aclk) begin
    if (data_areset) begin
      state_q <= ST_IDLE;
      resp_q <= RESP_OKAY;
      id_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q <= resp_d;
      id_q <= id_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      store_q <= store_d;
    end
  end
  assign data_awready = !data_areset && state_q == ST_IDLE;
  assign data_wready = !data_areset && state_q == ST_DATA;
  assign data_bvalid = !data_areset && state_q == ST_RESP;
  assign data_bid = id_q;
  assign data_bresp = resp_q;
  // a write landing on the reset edge belongs to an aborted burst and is dropped
  byte_enable_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(data_aclk),
    .rst(data_areset),
    .we_i(we && !data_areset),
    .waddr_i(idx_q),
    .wdata_i(data_wdata),
    .wstrb_i(data_wstrb),
    .raddr_i(debug_raddr),
    .rdata_o(debug_rdata)
  );
endmodule
